// File: rtl/sensor_record_playback.sv
// Records sensor words into a small snapshot memory at a divided sample rate
// and replays them, optionally looping, with a registered passthrough otherwise.
module sensor_record_playback #(
    parameter int WIDTH    = 24,
    parameter int DEPTH    = 16,
    parameter int RATE_DIV = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         sensor_input,
    input  logic                     save_signal,
    input  logic                     load_signal,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [WIDTH-1:0]         sensor_out,
    output logic [1:0]               state_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [31:0]              load_counter
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    localparam logic [DW-1:0] DIV_LAST   = DW'(RATE_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic             save_prev_q, save_prev_d;
    logic             load_prev_q, load_prev_d;
    logic [DW-1:0]    div_q, div_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      load_cnt_q, load_cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;

    logic save_edge;
    logic load_edge;
    logic tick;
    logic last_entry;

    always_comb begin
        save_edge  = save_signal & ~save_prev_q;
        load_edge  = load_signal & ~load_prev_q;
        tick       = (div_q == DIV_LAST);
        last_entry = (CW'(rd_ptr_q) == (count_q - CW'(1)));
    end

    always_comb begin
        state_d     = state_q;
        save_prev_d = save_signal;
        load_prev_d = load_signal;
        div_d       = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        load_cnt_d  = load_cnt_q;
        out_d       = sensor_input;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Save wins over a coincident load; loads need stored data.
                if (save_edge) begin
                    state_d  = ST_RECORD;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (load_edge && (count_q != '0)) begin
                    state_d    = ST_PLAY;
                    rd_ptr_d   = '0;
                    load_cnt_d = '0;
                end
            end

            ST_RECORD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    div_d = tick ? '0 : div_q + DW'(1);
                    if (tick) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                        if (count_q == COUNT_FULL - CW'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_PLAY: begin
                // Replayed word is held between ticks and for one cycle after exit.
                out_d = out_q;
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    div_d = tick ? '0 : div_q + DW'(1);
                    if (tick) begin
                        out_d      = mem[rd_ptr_q];
                        load_cnt_d = load_cnt_q + 32'd1;
                        if (last_entry) begin
                            rd_ptr_d = '0;
                            if (!loop_en) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            save_prev_q <= 1'b0;
            load_prev_q <= 1'b0;
            div_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            load_cnt_q  <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            save_prev_q <= save_prev_d;
            load_prev_q <= load_prev_d;
            div_q       <= div_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            load_cnt_q  <= load_cnt_d;
            out_q       <= out_d;
        end
    end

    // Snapshot storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= sensor_input;
        end
    end

    always_comb begin
        sensor_out   = out_q;
        state_out    = state_q;
        count        = count_q;
        full         = (count_q == COUNT_FULL);
        empty        = (count_q == '0);
        load_counter = load_cnt_q;
    end

endmodule

// File: tb/tb_sensor_record_playback.sv
// Directed and randomized bench for sensor_record_playback, compared every
// cycle against a queue-based behavioural model of record/playback.
module tb_sensor_record_playback;

    localparam int WIDTH    = 24;
    localparam int DEPTH    = 4;
    localparam int RATE_DIV = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] sensor_input = '0;
    logic             save_signal = 1'b0;
    logic             load_signal = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [WIDTH-1:0] sensor_out;
    logic [1:0]       state_out;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic [31:0]      load_counter;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_store[$];
    logic [WIDTH-1:0] m_out;
    int               m_mode;
    int               m_k;
    int               m_rd;
    logic [31:0]      m_lc;
    logic             m_ps;
    logic             m_pl;

    sensor_record_playback #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RATE_DIV(RATE_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sensor_input(sensor_input),
        .save_signal(save_signal),
        .load_signal(load_signal),
        .stop(stop),
        .loop_en(loop_en),
        .sensor_out(sensor_out),
        .state_out(state_out),
        .count(count),
        .full(full),
        .empty(empty),
        .load_counter(load_counter)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_store.delete();
        m_out  = '0;
        m_mode = 0;
        m_k    = 0;
        m_rd   = 0;
        m_lc   = '0;
        m_ps   = 1'b0;
        m_pl   = 1'b0;
    endtask

    // One rising edge of the reference: modes 0=idle, 1=record, 2=play.
    task automatic model_step();
        logic se, le;
        logic [WIDTH-1:0] nout;
        se   = save_signal && !m_ps;
        le   = load_signal && !m_pl;
        m_ps = save_signal;
        m_pl = load_signal;
        nout = (m_mode == 2) ? m_out : sensor_input;
        case (m_mode)
            0: begin
                if (se) begin
                    m_mode = 1;
                    m_store.delete();
                    m_k = 0;
                end else if (le && m_store.size() > 0) begin
                    m_mode = 2;
                    m_rd   = 0;
                    m_lc   = '0;
                    m_k    = 0;
                end
            end
            1: begin
                m_k++;
                if (stop) m_mode = 0;
                else if (m_k % RATE_DIV == 0) begin
                    m_store.push_back(sensor_input);
                    if (m_store.size() == DEPTH) m_mode = 0;
                end
            end
            default: begin
                m_k++;
                if (stop) m_mode = 0;
                else if (m_k % RATE_DIV == 0) begin
                    nout = m_store[m_rd];
                    m_lc = m_lc + 32'd1;
                    if (m_rd == m_store.size() - 1) begin
                        if (loop_en) m_rd = 0;
                        else m_mode = 0;
                    end else begin
                        m_rd++;
                    end
                end
            end
        endcase
        m_out = nout;
    endtask

    task automatic compare_all();
        check_val("sensor_out", sensor_out, m_out);
        check_val("state_out", state_out, m_mode);
        check_val("count", count, m_store.size());
        check_val("full", full, m_store.size() == DEPTH);
        check_val("empty", empty, m_store.size() == 0);
        check_val("load_counter", load_counter, m_lc);
    endtask

    task automatic set_in(input logic s, input logic l, input logic st, input logic lp,
                          input logic [WIDTH-1:0] d);
        save_signal  = s;
        load_signal  = l;
        stop         = st;
        loop_en      = lp;
        sensor_input = d;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"}, state_out, 0);
        check_val({tag, "_count"}, count, 0);
        check_val({tag, "_full"}, full, 0);
        check_val({tag, "_empty"}, empty, 1);
        check_val({tag, "_out"}, sensor_out, 0);
        check_val({tag, "_lc"}, load_counter, 0);
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic do_reset_mid();
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] seq [4];
        logic lp;
        seq[0] = 24'h11; seq[1] = 24'h22; seq[2] = 24'h33; seq[3] = 24'h44;
        model_reset();
        @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Record four samples
        set_in(1, 0, 0, 0, '0);
        cycle();
        check_val("rec_enter", state_out, 1);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, seq[i]);
            repeat (RATE_DIV) cycle();
        end
        check_val("rec_count", count, 4);
        check_val("rec_full", full, 1);
        check_val("rec_idle", state_out, 0);

        // Single playback
        set_in(0, 1, 0, 0, '0);
        cycle();
        check_val("play_enter", state_out, 2);
        set_in(0, 0, 0, 0, 24'h5);
        for (int i = 0; i < 4; i++) begin
            repeat (RATE_DIV) cycle();
            check_val("play_word", sensor_out, seq[i]);
        end
        check_val("play_end_state", state_out, 0);
        check_val("play_end_lc", load_counter, 4);
        cycle();
        check_val("passthrough_resume", sensor_out, 24'h5);

        // Looping playback, then stop
        set_in(0, 1, 0, 1, '0);
        cycle();
        set_in(0, 0, 0, 1, '0);
        for (int i = 0; i < 6; i++) begin
            repeat (RATE_DIV) cycle();
            check_val("loop_word", sensor_out, seq[i % 4]);
        end
        check_val("loop_lc", load_counter, 6);
        set_in(0, 0, 1, 1, '0);
        cycle();
        check_val("loop_stop_state", state_out, 0);
        set_in(0, 0, 0, 0, '0);
        cycle();
        check_val("loop_lc_held", load_counter, 6);

        // Abort record after two ticks
        set_in(1, 0, 0, 0, '0);
        cycle();
        set_in(0, 0, 0, 0, 24'hA1);
        repeat (RATE_DIV) cycle();
        set_in(0, 0, 0, 0, 24'hA2);
        repeat (RATE_DIV) cycle();
        set_in(0, 0, 1, 0, 24'hA3);
        cycle();
        check_val("abort_count", count, 2);
        check_val("abort_full", full, 0);
        check_val("abort_state", state_out, 0);
        set_in(0, 1, 0, 0, '0);
        cycle();
        set_in(0, 0, 0, 0, '0);
        repeat (RATE_DIV) cycle();
        check_val("abort_word0", sensor_out, 24'hA1);
        repeat (RATE_DIV) cycle();
        check_val("abort_word1", sensor_out, 24'hA2);
        check_val("abort_play_end", state_out, 0);
        check_val("abort_lc", load_counter, 2);

        // Corners: save+load together, load while empty, save during play
        set_in(1, 1, 0, 0, '0);
        cycle();
        check_val("save_wins", state_out, 1);
        set_in(0, 0, 1, 0, '0);
        cycle();
        check_val("empty_after_stop", empty, 1);
        set_in(0, 1, 0, 0, '0);
        cycle();
        check_val("load_when_empty", state_out, 0);
        set_in(1, 0, 0, 0, '0);
        cycle();
        set_in(0, 0, 0, 0, 24'h77);
        repeat (DEPTH * RATE_DIV) cycle();
        check_val("refill_full", full, 1);
        set_in(0, 1, 0, 0, '0);
        cycle();
        set_in(1, 0, 0, 0, '0);
        cycle();
        check_val("save_in_play", state_out, 2);
        cycle();
        do_reset_mid();

        // Randomized traffic with occasional asynchronous resets
        lp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset_mid();
            if (n % 64 == 0) lp = 1'($urandom_range(0, 1));
            set_in($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 23) == 0, lp, WIDTH'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_record_playback.md
SENSOR_RECORD_PLAYBACK -- requirements
Module: sensor_record_playback

Interface
REQ-001 Parameter WIDTH, default 24: sensor word width in bits.
REQ-002 Parameter DEPTH, default 16: snapshot memory entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RATE_DIV, default 1: clock cycles per sample tick; SHALL be at least 1.
REQ-004 clock  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sensor_input  in  WIDTH  live sensor word.
REQ-007 save_signal  in  1  level; rising edge requests record.
REQ-008 load_signal  in  1  level; rising edge requests playback.
REQ-009 stop  in  1  level; aborts record or playback.
REQ-010 loop_en  in  1  playback wraps to entry 0 instead of ending.
REQ-011 sensor_out  out  WIDTH  registered live or replayed sensor word.
REQ-012 state_out  out  2  0=IDLE, 1=RECORD, 2=PLAY.
REQ-013 count  out  $clog2(DEPTH)+1  number of valid stored entries.
REQ-014 full  out  1  count==DEPTH.
REQ-015 empty  out  1  count==0.
REQ-016 load_counter  out  32  samples emitted since the last PLAY entry.

Function
REQ-017 Edge detect: registered copies of save_signal and load_signal SHALL be kept; an edge is current=1 and previous=0.
REQ-018 Edge detects SHALL act only in IDLE; edges in RECORD or PLAY SHALL be discarded.
REQ-019 In IDLE, a save edge SHALL enter RECORD on the next cycle, clear count, and clear the write pointer.
REQ-020 In IDLE, a load edge with count>0 SHALL enter PLAY, clear the read pointer, and clear load_counter.
REQ-021 In IDLE, a load edge with count==0 SHALL be ignored.
REQ-022 If save and load edges occur in the same IDLE cycle, save SHALL win.
REQ-023 Tick divider: counts 0..RATE_DIV-1 in RECORD/PLAY; tick when value==RATE_DIV-1; cleared on every state entry; held at 0 in IDLE. The first tick therefore occurs RATE_DIV cycles after entry.
REQ-024 RECORD tick: mem[write ptr] <= sensor_input; write ptr++; count++.
REQ-025 When the write that makes count==DEPTH occurs, the state SHALL return to IDLE in the same edge; full=1.
REQ-026 PLAY tick: sensor_out <= mem[read ptr]; load_counter++ (wraps at 2^32); read ptr++.
REQ-027 PLAY, tick with read ptr==count-1: if loop_en, read ptr <= 0 and remain in PLAY; otherwise go to IDLE after emitting.
REQ-028 stop=1 in RECORD or PLAY SHALL force IDLE on the next edge and take priority over a coincident tick; that tick's write or emit is suppressed; count is retained.
REQ-029 In IDLE and RECORD, sensor_out SHALL be sensor_input registered (1-cycle latency).
REQ-030 On PLAY exit, sensor_out SHALL hold the last replayed word for 1 cycle, then resume passthrough.
REQ-031 Memory contents are not reset; reads are only ever issued to entries below count.
REQ-032 count, full, empty, and load_counter SHALL hold in IDLE.

Reset
REQ-033 On reset: state_out=0, count=0, full=0, empty=1, sensor_out=0, load_counter=0, pointers=0, tick divider=0, edge registers=0.
REQ-034 Reset asserted mid-RECORD or mid-PLAY SHALL abort immediately with the REQ-033 values; the first edge after release SHALL behave as IDLE.

Verification (WIDTH=24, DEPTH=4, RATE_DIV=2)
REQ-035 Record: save edge; inputs 0x11,0x22,0x33,0x44 on successive ticks -> count=4, full=1, state_out=0 after the 4th tick.
REQ-036 Playback: load edge, loop_en=0 -> sensor_out 0x11,0x22,0x33,0x44 at 2-cycle spacing; load_counter=4; return to IDLE.
REQ-037 Loop: loop_en=1, 6 ticks -> sequence 0x11,0x22,0x33,0x44,0x11,0x22; load_counter=6; stop -> IDLE and counter held at 6.
REQ-038 Abort: stop after 2 record ticks -> count=2, full=0; a following load replays 2 entries only.
REQ-039 Corners: save and load in the same cycle -> RECORD; load with count=0 -> stays IDLE; save edge during PLAY -> ignored.
REQ-040 Reset mid-PLAY -> all outputs at REQ-033 values asynchronously, before the next clock edge.
